// File: rtl/dw_fifo_pop_stream.sv
// rtl/dw_fifo_pop_stream.sv - FIFO pop-side reader presenting words as a registered valid/ready stream
//
// Purpose:
//   Sits in the pop clock domain of a fall-through FIFO and drives its pop
//   interface. Popped words go into a 2-entry output buffer: slot0 is the
//   head and drives out_data, slot1 is the skid slot.
//
// Optional feature macro: FIFO_POP_WCNT_EN (adds out_word_count and its counter)
//
// Ports:
//   clk            in   pop-domain clock, rising edge
//   reset          in   synchronous active-high reset
//   flush          in   drop all buffered words, no pop in that cycle
//   pop_empty      in   FIFO empty flag
//   pop_error      in   FIFO pop error flag
//   fifo_data      in   word at the FIFO head (valid while pop_req_n is low)
//   pop_req_n      out  active-low pop request to the FIFO
//   out_valid      out  out_data holds a valid word
//   out_ready      in   downstream accepts when out_valid & out_ready
//   out_data       out  head word of the output buffer
//   err_flag       out  sticky (err_mode=0) or one-cycle-delayed (err_mode=1) pop error
//   out_word_count out  accepted-word count, FIFO_POP_WCNT_EN only

module dw_fifo_pop_stream #(
  parameter int width     = 8,
  parameter int err_mode  = 0,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 pop_empty,
  input  logic                 pop_error,
  input  logic [width-1:0]     fifo_data,
  output logic                 pop_req_n,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [width-1:0]     out_data,
`ifdef FIFO_POP_WCNT_EN
  output logic [cnt_width-1:0] out_word_count,
`endif
  output logic                 err_flag
);

  logic [1:0]       cnt_q, cnt_d;
  logic [width-1:0] slot0_q, slot0_d;
  logic [width-1:0] slot1_q, slot1_d;
  logic             valid_q;
  logic             err_q, err_d;
  logic             pop;
  logic             acc;

  // Pop decision uses only registered occupancy, so out_ready never reaches
  // the FIFO combinationally.
  assign pop_req_n = ~(~reset & ~flush & ~pop_empty & (cnt_q != 2'd2));
  assign pop       = ~pop_req_n;
  assign acc       = valid_q & out_ready;

  always_comb begin
    cnt_d   = cnt_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      // Slots keep their contents; out_data simply holds the old head.
      cnt_d = 2'd0;
    end else begin
      unique case ({pop, acc})
        2'b10: begin
          if (cnt_q == 2'd0) slot0_d = fifo_data;
          else               slot1_d = fifo_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          // Draining the last word leaves slot0 untouched so out_data holds.
          if (cnt_q == 2'd2) slot0_d = slot1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Only reachable at cnt=1: the new word replaces the departing head.
          slot0_d = fifo_data;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (err_mode == 0) err_d = err_q | pop_error;
    else               err_d = pop_error;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 2'd0;
      slot0_q <= '0;
      slot1_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      valid_q <= (cnt_d != 2'd0);
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = slot0_q;
  assign err_flag  = err_q;

`ifdef FIFO_POP_WCNT_EN
  logic [cnt_width-1:0] wcnt_q;

  // Counts accepts including one in a flush cycle; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)    wcnt_q <= '0;
    else if (acc) wcnt_q <= wcnt_q + cnt_width'(1);
  end

  assign out_word_count = wcnt_q;
`endif

endmodule

// File: tb/tb_dw_fifo_pop_stream.sv
// tb/tb_dw_fifo_pop_stream.sv - self-checking bench for dw_fifo_pop_stream
module tb_dw_fifo_pop_stream;

  localparam int W  = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, flush, pop_empty, pop_error, out_ready;
  logic [W-1:0] fifo_data;
  wire          pop_req_n, out_valid, err_flag;
  wire  [W-1:0] out_data;
  wire          prn1, ov1, err1;
  wire  [W-1:0] od1;
`ifdef FIFO_POP_WCNT_EN
  wire [CW-1:0] wcnt, wcnt1;
`endif

  dw_fifo_pop_stream #(.width(W), .err_mode(0), .cnt_width(CW)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .pop_empty(pop_empty),
    .pop_error(pop_error), .fifo_data(fifo_data), .pop_req_n(pop_req_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef FIFO_POP_WCNT_EN
    .out_word_count(wcnt),
`endif
    .err_flag(err_flag));

  dw_fifo_pop_stream #(.width(W), .err_mode(1), .cnt_width(CW)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .pop_empty(pop_empty),
    .pop_error(pop_error), .fifo_data(fifo_data), .pop_req_n(prn1),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
`ifdef FIFO_POP_WCNT_EN
    .out_word_count(wcnt1),
`endif
    .err_flag(err1));

  int nvec = 0;
  int nerr = 0;

  // FIFO contents, model output buffer, and observation logs
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] mbuf[$];
  logic [W-1:0] last_data;
  bit           m_err0, m_err1;
  int           m_wcnt;
  int           npops, cyc;
  logic [W-1:0] acc_log[$];
  int           acc_cyc[$];
  int           pop_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    npops = 0;
    cyc   = 0;
    acc_log.delete();
    acc_cyc.delete();
    pop_cyc.delete();
  endtask

  // One cycle: drive inputs, compare all outputs against the model, clock,
  // then advance the FIFO and the model.
  task automatic step(input bit rst, input bit fl, input bit rdy, input bit perr);
    bit           exp_prn, mpop, macc, dut_pop;
    logic [W-1:0] head, exp_data;
    reset     = rst;
    flush     = fl;
    out_ready = rdy;
    pop_error = perr;
    pop_empty = (fifo_q.size() == 0);
    head      = pop_empty ? '0 : fifo_q[0];
    fifo_data = head;
    #1;
    exp_prn  = !(!rst && !fl && fifo_q.size() != 0 && mbuf.size() < 2);
    exp_data = (mbuf.size() != 0) ? mbuf[0] : last_data;
    chk("pop_req_n", pop_req_n, exp_prn);
    chk("out_valid", out_valid, mbuf.size() != 0);
    chk("out_data", out_data, exp_data);
    chk("err_flag_m0", err_flag, m_err0);
    chk("err_flag_m1", err1, m_err1);
`ifdef FIFO_POP_WCNT_EN
    chk("out_word_count", wcnt, m_wcnt);
`endif
    dut_pop = (pop_req_n === 1'b0);
    if (dut_pop) begin
      npops++;
      pop_cyc.push_back(cyc);
    end
    if (out_valid === 1'b1 && rdy) begin
      acc_log.push_back(out_data);
      acc_cyc.push_back(cyc);
    end
    mpop = !exp_prn;
    macc = (mbuf.size() != 0) && rdy;
    @(posedge clk);
    if (dut_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    if (rst) begin
      mbuf.delete();
      last_data = '0;
      m_err0    = 1'b0;
      m_err1    = 1'b0;
      m_wcnt    = 0;
    end else begin
      if (macc) m_wcnt = (m_wcnt + 1) % (1 << CW);
      m_err0 = m_err0 | perr;
      m_err1 = perr;
      if (fl) begin
        if (mbuf.size() != 0) last_data = mbuf[0];
        mbuf.delete();
      end else begin
        if (macc) last_data = mbuf.pop_front();
        if (mpop) mbuf.push_back(head);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_seq(input string name, input logic [W-1:0] base, input int n);
    chk({name, "_count"}, acc_log.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] got;
      got = (i < acc_log.size()) ? acc_log[i] : 'x;
      chk({name, "_word"}, got, base + W'(i));
    end
  endtask

  initial begin
    int p0;
    logic [W-1:0] e1[3];
    e1 = '{8'h11, 8'h22, 8'h33};
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0; pop_error = 1'b0;
    pop_empty = 1'b1; fifo_data = '0;
    mbuf.delete(); last_data = '0; m_err0 = 0; m_err1 = 0; m_wcnt = 0;
    clear_logs();
    @(posedge clk);
    @(negedge clk);

    // Reset state, then three-word burst with out_ready high
    step(1, 0, 1, 0);
    clear_logs();
    fifo_q = '{8'h11, 8'h22, 8'h33};
    repeat (6) step(0, 0, 1, 0);
    chk("s1_pops", npops, 3);
    chk("s1_acc_count", acc_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("s1_word", (i < acc_log.size()) ? acc_log[i] : 'x, e1[i]);
      chk("s1_pop_cycle", (i < pop_cyc.size()) ? pop_cyc[i] : -1, i);
      chk("s1_acc_cycle", (i < acc_cyc.size()) ? acc_cyc[i] : -1, i + 1);
    end

    // Backpressure: exactly two pops, then in-order gapless drain
    step(1, 0, 0, 0);
    clear_logs();
    for (int i = 0; i < 5; i++) fifo_q.push_back(8'h41 + W'(i));
    repeat (4) step(0, 0, 0, 0);
    chk("s2_pops", npops, 2);
    chk("s2_fifo_left", fifo_q.size(), 3);
    chk("s2_no_acc", acc_log.size(), 0);
    repeat (8) step(0, 0, 1, 0);
    check_seq("s2", 8'h41, 5);
    for (int i = 1; i < 5; i++)
      chk("s2_gapless", (i < acc_cyc.size()) ? acc_cyc[i] - acc_cyc[0] : -1, i);

    // Toggling out_ready
    step(1, 0, 0, 0);
    clear_logs();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h81 + W'(i));
    for (int i = 0; i < 24; i++) step(0, 0, (i % 2) == 0, 0);
    check_seq("s3", 8'h81, 8);

    // Flush with two words buffered
    step(1, 0, 0, 0);
    clear_logs();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA1 + W'(i));
    repeat (3) step(0, 0, 0, 0);
    chk("s4_pre_valid", out_valid, 1'b1);
    p0 = npops;
    step(0, 1, 0, 0);
    chk("s4_flush_no_pop", npops, p0);
    chk("s4_flush_valid", out_valid, 1'b0);
    clear_logs();
    repeat (6) step(0, 0, 1, 0);
    check_seq("s4", 8'hA3, 2);

    // One-cycle pop_error pulse in both error modes
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("s5_m0_set", err_flag, 1'b1);
    chk("s5_m1_set", err1, 1'b1);
    step(0, 0, 0, 0);
    chk("s5_m0_hold", err_flag, 1'b1);
    chk("s5_m1_clear", err1, 1'b0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("s5_m0_flush_keeps", err_flag, 1'b1);
    step(1, 0, 0, 0);
    chk("s5_m0_reset", err_flag, 1'b0);

    // 18 accepted words
    clear_logs();
    for (int i = 0; i < 18; i++) fifo_q.push_back(8'h20 + W'(i));
    repeat (22) step(0, 0, 1, 0);
    check_seq("s6", 8'h20, 18);
`ifdef FIFO_POP_WCNT_EN
    chk("s6_wrap", wcnt, 2);
`endif

    // Reset mid-transfer
    step(1, 0, 0, 0);
    clear_logs();
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hC1 + W'(i));
    repeat (2) step(0, 0, 1, 0);
    p0 = npops;
    step(1, 0, 1, 0);
    chk("s7_reset_no_pop", npops, p0);
    chk("s7_valid", out_valid, 1'b0);
    chk("s7_fifo_left", fifo_q.size(), 2);
`ifdef FIFO_POP_WCNT_EN
    chk("s7_wcnt", wcnt, 0);
`endif
    clear_logs();
    repeat (5) step(0, 0, 1, 0);
    check_seq("s7", 8'hC3, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
